// File: rtl/single_port_ram_core.sv
// Single-port RAM: one read or write per enabled cycle on a shared address, sync clear on reset.
// Latency: read data and Valid_out appear one cycle after the edge that samples the request.
// Backpressure: none; every enabled request is accepted and the outputs are driven directly.
module single_port_ram_core #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Enable,
    input  logic                  Write_en,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Valid_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;

    always_comb begin
        mem_d       = mem_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        if (Enable) begin
            if (Write_en) begin
                mem_d[Address] = Data_in;
            end else begin
                data_out_d  = mem_q[Address];
                valid_out_d = 1'b1;
            end
        end
    end

    // The whole array is built from flops so that reset can clear every word in one edge.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign Data_out  = data_out_q;
    assign Valid_out = valid_out_q;

endmodule

// File: tb/tb_single_port_ram_core.sv
// Directed vector table plus a randomized scoreboard run with a mid-stream reset.
module tb_single_port_ram_core;

    logic       Clock;
    logic       Resetn;
    logic       Enable;
    logic       Write_en;
    logic [5:0] Address;
    logic [7:0] Data_in;
    logic [7:0] Data_out;
    logic       Valid_out;

    int checks_made;
    int checks_failed;

    single_port_ram_core #(.ADDR_WIDTH(6), .DATA_WIDTH(8)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Enable   (Enable),
        .Write_en (Write_en),
        .Address  (Address),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .Valid_out(Valid_out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       rst;
        logic       en;
        logic       we;
        logic [5:0] addr;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[20];

    logic [7:0] model [64];
    logic [7:0] exp_dout;
    logic       exp_vld;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks_made++;
        if (act !== exp) begin
            checks_failed++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    // Present one request, let it be sampled, then look at the outputs 1 ns after the edge.
    task automatic step(input logic rst, input logic en, input logic we,
                        input logic [5:0] addr, input logic [7:0] din);
        Resetn   = rst;
        Enable   = en;
        Write_en = we;
        Address  = addr;
        Data_in  = din;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int r;
        logic [5:0] a;
        logic [7:0] d;

        checks_made   = 0;
        checks_failed = 0;
        Resetn = 1'b1; Enable = 1'b0; Write_en = 1'b0; Address = '0; Data_in = '0;

        //            rst   en    we    addr   din    dout   vld
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 6'h00, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 6'h3F, 8'h00, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 6'h3F, 8'h00, 8'h00, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 6'h00, 8'hA5, 8'h00, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 6'h3F, 8'h5A, 8'h00, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'hA5, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 6'h3F, 8'h00, 8'h5A, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 6'h10, 8'h11, 8'h5A, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 6'h10, 8'h00, 8'h11, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 6'h10, 8'hFF, 8'h11, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 6'h10, 8'h00, 8'h11, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 6'h00, 8'h01, 8'h11, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 6'h01, 8'h02, 8'h11, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 6'h02, 8'h03, 8'h11, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 6'h03, 8'h04, 8'h11, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'h00, 8'h01, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 6'h01, 8'h00, 8'h02, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 6'h02, 8'h00, 8'h03, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 6'h03, 8'h00, 8'h04, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 6'h03, 8'h00, 8'h04, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d_dout", i), Data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_vld", i), {7'd0, Valid_out}, {7'd0, vecs[i].exp_vld});
        end

        // Reset landing in the middle of a run of reads wipes both outputs and memory.
        step(1'b0, 1'b1, 1'b0, 6'h02, 8'h00);
        check("rdrun_before_rst", Data_out, 8'h03);
        step(1'b1, 1'b1, 1'b0, 6'h03, 8'h00);
        check("rdrun_rst_dout", Data_out, 8'h00);
        check("rdrun_rst_vld", {7'd0, Valid_out}, 8'h00);
        step(1'b0, 1'b1, 1'b0, 6'h02, 8'h00);
        check("rdrun_after_rst_dout", Data_out, 8'h00);
        check("rdrun_after_rst_vld", {7'd0, Valid_out}, 8'h01);

        // Randomized mix against a behavioural model; a reset is forced halfway through.
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
        exp_dout = 8'h00;
        for (int i = 0; i < 96; i++) begin
            r = $urandom_range(0, 9);
            a = 6'($urandom_range(0, 15));
            d = 8'($urandom);
            if (i == 48) begin
                step(1'b1, 1'b1, 1'b1, a, d);
                for (int j = 0; j < 64; j++) model[j] = 8'h00;
                exp_dout = 8'h00;
                exp_vld  = 1'b0;
            end else if (r < 4) begin
                step(1'b0, 1'b1, 1'b1, a, d);
                model[a] = d;
                exp_vld  = 1'b0;
            end else if (r < 8) begin
                step(1'b0, 1'b1, 1'b0, a, d);
                exp_dout = model[a];
                exp_vld  = 1'b1;
            end else begin
                step(1'b0, 1'b0, r[0], a, d);
                exp_vld = 1'b0;
            end
            check($sformatf("rnd%0d_dout", i), Data_out, exp_dout);
            check($sformatf("rnd%0d_vld", i), {7'd0, Valid_out}, {7'd0, exp_vld});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks_made, checks_failed);
        $finish;
    end

endmodule
